// File: rtl/irda_dma_fifo.sv
// IrDA DMA FIFO: first-word-fall-through circular buffer with a programmable
// threshold flag and a three-state DMA request handshake. DIR_RX selects
// whether the threshold counts filled words (receive) or free slots (transmit).
module irda_dma_fifo #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter bit          DIR_RX     = 1'b0
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  fifo_clear,
  input  logic                  fifo_add,
  input  logic [DATA_W-1:0]     fifo_dat_i,
  input  logic                  fifo_remove,
  output logic [DATA_W-1:0]     fifo_dat_o,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  fifo_overrun,
  output logic                  fifo_underrun,
  input  logic [1:0]            trigger_level,
  output logic                  trig_o,
  input  logic                  use_dma,
  output logic                  dma_req_o,
  input  logic                  dma_ack_i
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {StIdle, StReq, StAcked} dma_state_e;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overrun_q, overrun_d;
  logic                  underrun_q, underrun_d;
  logic                  full, empty;
  logic                  do_push, do_pop, mem_we;
  logic [CW-1:0]         thr, space;
  dma_state_e            state_q, state_d;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Push/pop qualification and pointer/count next state; clear wins over both.
  always_comb begin
    // At full a simultaneous pop frees the slot, so the push still completes.
    do_push    = fifo_add && (!full || fifo_remove);
    do_pop     = fifo_remove && !empty;
    overrun_d  = fifo_add && full && !fifo_remove;
    underrun_d = fifo_remove && empty;
    mem_we     = do_push && !fifo_clear;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (fifo_clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end
  end

  // Pointer, count and error-pulse registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  // Storage array; contents survive clear and reset since count gates the output.
  always_ff @(posedge wb_clk_i) begin
    if (mem_we) mem_q[wr_ptr_q] <= fifo_dat_i;
  end

  // Threshold select and level flag.
  always_comb begin
    unique case (trigger_level)
      2'd0: thr = CW'(1);
      2'd1: thr = CW'(DEPTH / 4);
      2'd2: thr = CW'(DEPTH / 2);
      2'd3: thr = CW'(DEPTH - 2);
    endcase
    space  = CW'(DEPTH) - count_q;
    trig_o = DIR_RX ? (count_q >= thr) : (space >= thr);
  end

  assign fifo_dat_o    = empty ? '0 : mem_q[rd_ptr_q];
  assign fifo_count    = count_q;
  assign fifo_overrun  = overrun_q;
  assign fifo_underrun = underrun_q;

  // DMA FSM state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) state_q <= StIdle;
    else           state_q <= state_d;
  end

  // DMA FSM next state; ACKED holds off a new request until ack is released.
  always_comb begin
    state_d = state_q;
    if (fifo_clear || !use_dma) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (trig_o)     state_d = StReq;
        StReq:   if (dma_ack_i)  state_d = StAcked;
        StAcked: if (!dma_ack_i) state_d = StIdle;
        default:                 state_d = StIdle;
      endcase
    end
  end

  // DMA FSM outputs.
  always_comb begin
    dma_req_o = (state_q == StReq);
  end

endmodule

// File: tb/tb_irda_dma_fifo.sv
// Bench for irda_dma_fifo: a transmit-side and a receive-side instance share
// all inputs; a queue holds expected head words in push order.
module tb_irda_dma_fifo;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic        fifo_clear = 1'b0;
  logic        fifo_add = 1'b0;
  logic [31:0] fifo_dat_i = '0;
  logic        fifo_remove = 1'b0;
  logic [1:0]  trigger_level = 2'd0;
  logic        use_dma = 1'b0;
  logic        dma_ack_i = 1'b0;

  logic [31:0] tx_dat, rx_dat;
  logic [4:0]  tx_count, rx_count;
  logic        tx_ov, rx_ov, tx_un, rx_un, tx_trig, rx_trig, tx_req, rx_req;

  logic [31:0] sb[$];
  logic [31:0] exp_w;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  irda_dma_fifo #(.DATA_W(32), .DEPTH_LOG2(4), .DIR_RX(1'b0)) dut_tx (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .fifo_clear(fifo_clear),
    .fifo_add(fifo_add), .fifo_dat_i(fifo_dat_i), .fifo_remove(fifo_remove),
    .fifo_dat_o(tx_dat), .fifo_count(tx_count), .fifo_overrun(tx_ov),
    .fifo_underrun(tx_un), .trigger_level(trigger_level), .trig_o(tx_trig),
    .use_dma(use_dma), .dma_req_o(tx_req), .dma_ack_i(dma_ack_i)
  );

  irda_dma_fifo #(.DATA_W(32), .DEPTH_LOG2(4), .DIR_RX(1'b1)) dut_rx (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .fifo_clear(fifo_clear),
    .fifo_add(fifo_add), .fifo_dat_i(fifo_dat_i), .fifo_remove(fifo_remove),
    .fifo_dat_o(rx_dat), .fifo_count(rx_count), .fifo_overrun(rx_ov),
    .fifo_underrun(rx_un), .trigger_level(trigger_level), .trig_o(rx_trig),
    .use_dma(use_dma), .dma_req_o(rx_req), .dma_ack_i(dma_ack_i)
  );

  task automatic cyc();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic push_word(input logic [31:0] v);
    fifo_add   = 1'b1;
    fifo_dat_i = v;
    sb.push_back(v);
    cyc();
    fifo_add = 1'b0;
  endtask

  task automatic do_clear();
    fifo_clear = 1'b1;
    cyc();
    fifo_clear = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b0;
    #23;
    n_checks++;
    if (tx_count !== 5'd0) begin
      n_errors++; $display("FAIL reset_count got %0d want 0", tx_count);
    end
    n_checks++;
    if (tx_dat !== 32'h0) begin
      n_errors++; $display("FAIL reset_dat got %h want 0", tx_dat);
    end
    n_checks++;
    if ({tx_ov, tx_un, tx_req, rx_req} !== 4'b0) begin
      n_errors++; $display("FAIL reset_flags got %b want 0000", {tx_ov, tx_un, tx_req, rx_req});
    end
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    cyc();
  endtask

  task automatic test_fill_wrap();
    for (int i = 1; i <= 16; i++) push_word(32'(i));
    n_checks++;
    if (tx_count !== 5'd16) begin
      n_errors++; $display("FAIL fill_count got %0d want 16", tx_count);
    end
    fifo_add = 1'b1; fifo_dat_i = 32'h11;
    cyc();
    fifo_add = 1'b0;
    n_checks++;
    if (tx_ov !== 1'b1 || tx_count !== 5'd16) begin
      n_errors++; $display("FAIL overrun got ov=%b cnt=%0d want ov=1 cnt=16", tx_ov, tx_count);
    end
    cyc();
    n_checks++;
    if (tx_ov !== 1'b0) begin
      n_errors++; $display("FAIL overrun_pulse got %b want 0", tx_ov);
    end
    for (int i = 0; i < 16; i++) begin
      exp_w = sb.pop_front();
      n_checks++;
      if (tx_dat !== exp_w) begin
        n_errors++; $display("FAIL drain_head got %h want %h", tx_dat, exp_w);
      end
      fifo_remove = 1'b1;
      cyc();
    end
    fifo_remove = 1'b0;
    n_checks++;
    if (tx_count !== 5'd0 || tx_dat !== 32'h0) begin
      n_errors++; $display("FAIL drain_empty got cnt=%0d dat=%h want 0/0", tx_count, tx_dat);
    end
    fifo_remove = 1'b1;
    cyc();
    fifo_remove = 1'b0;
    n_checks++;
    if (tx_un !== 1'b1 || tx_dat !== 32'h0) begin
      n_errors++; $display("FAIL underrun got un=%b dat=%h want 1/0", tx_un, tx_dat);
    end
    cyc();
    n_checks++;
    if (tx_un !== 1'b0) begin
      n_errors++; $display("FAIL underrun_pulse got %b want 0", tx_un);
    end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 16; i++) push_word(32'hC000 + 32'(i));
    exp_w = sb.pop_front();
    sb.push_back(32'hBEEF);
    fifo_add = 1'b1; fifo_dat_i = 32'hBEEF; fifo_remove = 1'b1;
    cyc();
    fifo_add = 1'b0; fifo_remove = 1'b0;
    n_checks++;
    if (tx_ov !== 1'b0 || tx_count !== 5'd16) begin
      n_errors++; $display("FAIL full_simul got ov=%b cnt=%0d want 0/16", tx_ov, tx_count);
    end
    while (sb.size() > 0) begin
      exp_w = sb.pop_front();
      n_checks++;
      if (tx_dat !== exp_w) begin
        n_errors++; $display("FAIL full_simul_head got %h want %h", tx_dat, exp_w);
      end
      fifo_remove = 1'b1;
      cyc();
    end
    fifo_remove = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) push_word(32'hB000 + 32'(i));
    for (int i = 3; i < 33; i++) begin
      exp_w = sb.pop_front();
      n_checks++;
      if (tx_dat !== exp_w || tx_count !== 5'd3) begin
        n_errors++;
        $display("FAIL b2b got dat=%h cnt=%0d want %h/3", tx_dat, tx_count, exp_w);
      end
      sb.push_back(32'hB000 + 32'(i));
      fifo_add = 1'b1; fifo_dat_i = 32'hB000 + 32'(i); fifo_remove = 1'b1;
      cyc();
    end
    fifo_add = 1'b0; fifo_remove = 1'b0;
    do_clear();
  endtask

  task automatic test_simul_empty();
    fifo_add = 1'b1; fifo_dat_i = 32'hA5; fifo_remove = 1'b1;
    cyc();
    fifo_add = 1'b0; fifo_remove = 1'b0;
    n_checks++;
    if (tx_un !== 1'b1 || tx_count !== 5'd1 || tx_dat !== 32'hA5) begin
      n_errors++;
      $display("FAIL simul_empty got un=%b cnt=%0d dat=%h want 1/1/a5", tx_un, tx_count, tx_dat);
    end
    do_clear();
  endtask

  task automatic test_rx_dma();
    trigger_level = 2'd2;
    use_dma = 1'b1;
    for (int i = 0; i < 8; i++) push_word(32'hD0 + 32'(i));
    n_checks++;
    if (rx_trig !== 1'b1 || rx_req !== 1'b0) begin
      n_errors++; $display("FAIL rx_trig got trig=%b req=%b want 1/0", rx_trig, rx_req);
    end
    cyc();
    n_checks++;
    if (rx_req !== 1'b1) begin
      n_errors++; $display("FAIL rx_req_rise got %b want 1", rx_req);
    end
    dma_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (rx_req !== 1'b0) begin
        n_errors++; $display("FAIL rx_req_acked cycle %0d got %b want 0", i, rx_req);
      end
    end
    dma_ack_i = 1'b0;
    cyc();
    n_checks++;
    if (rx_req !== 1'b0) begin
      n_errors++; $display("FAIL rx_req_idle got %b want 0", rx_req);
    end
    cyc();
    n_checks++;
    if (rx_req !== 1'b1) begin
      n_errors++; $display("FAIL rx_req_rearm got %b want 1", rx_req);
    end
    use_dma = 1'b0;
    cyc();
    n_checks++;
    if (rx_req !== 1'b0) begin
      n_errors++; $display("FAIL rx_use_dma_drop got %b want 0", rx_req);
    end
    do_clear();
  endtask

  task automatic test_tx_dma();
    trigger_level = 2'd3;
    use_dma = 1'b0;
    for (int i = 0; i < 3; i++) push_word(32'hE0 + 32'(i));
    use_dma = 1'b1;
    n_checks++;
    if (tx_trig !== 1'b0) begin
      n_errors++; $display("FAIL tx_trig_cnt3 got %b want 0", tx_trig);
    end
    cyc();
    n_checks++;
    if (tx_req !== 1'b0) begin
      n_errors++; $display("FAIL tx_req_cnt3 got %b want 0", tx_req);
    end
    fifo_remove = 1'b1;
    cyc();
    fifo_remove = 1'b0;
    n_checks++;
    if (tx_trig !== 1'b1 || tx_req !== 1'b0 || tx_count !== 5'd2) begin
      n_errors++;
      $display("FAIL tx_trig_cnt2 got trig=%b req=%b cnt=%0d want 1/0/2", tx_trig, tx_req, tx_count);
    end
    cyc();
    n_checks++;
    if (tx_req !== 1'b1) begin
      n_errors++; $display("FAIL tx_req_rise got %b want 1", tx_req);
    end
    use_dma = 1'b0;
    do_clear();
  endtask

  task automatic test_clear_priority();
    trigger_level = 2'd0;
    use_dma = 1'b1;
    for (int i = 0; i < 5; i++) push_word(32'hF0 + 32'(i));
    n_checks++;
    if (tx_req !== 1'b1 || tx_count !== 5'd5) begin
      n_errors++; $display("FAIL clr_setup got req=%b cnt=%0d want 1/5", tx_req, tx_count);
    end
    fifo_clear = 1'b1; fifo_add = 1'b1; fifo_dat_i = 32'h99; fifo_remove = 1'b1;
    cyc();
    fifo_clear = 1'b0; fifo_add = 1'b0; fifo_remove = 1'b0;
    sb.delete();
    n_checks++;
    if (tx_count !== 5'd0 || tx_req !== 1'b0 || rx_req !== 1'b0 || tx_ov !== 1'b0 ||
        tx_un !== 1'b0 || tx_dat !== 32'h0) begin
      n_errors++;
      $display("FAIL clear_prio got cnt=%0d req=%b ov=%b un=%b dat=%h want 0/0/0/0/0",
               tx_count, tx_req, tx_ov, tx_un, tx_dat);
    end
    use_dma = 1'b0;
    cyc();
  endtask

  task automatic test_async_reset();
    trigger_level = 2'd0;
    use_dma = 1'b1;
    for (int i = 0; i < 9; i++) push_word(32'h70 + 32'(i));
    n_checks++;
    if (tx_req !== 1'b1 || tx_count !== 5'd9) begin
      n_errors++; $display("FAIL arst_setup got req=%b cnt=%0d want 1/9", tx_req, tx_count);
    end
    #3;
    wb_rst_i = 1'b0;
    #1;
    n_checks++;
    if (tx_count !== 5'd0 || tx_dat !== 32'h0 || tx_req !== 1'b0 || rx_req !== 1'b0 ||
        tx_ov !== 1'b0 || tx_un !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset got cnt=%0d dat=%h req=%b ov=%b un=%b want all 0",
               tx_count, tx_dat, tx_req, tx_ov, tx_un);
    end
    sb.delete();
    use_dma = 1'b0;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i   = 1'b1;
    fifo_add   = 1'b1;
    fifo_dat_i = 32'h55;
    cyc();
    fifo_add = 1'b0;
    n_checks++;
    if (tx_count !== 5'd1 || tx_dat !== 32'h55) begin
      n_errors++; $display("FAIL first_push got cnt=%0d dat=%h want 1/55", tx_count, tx_dat);
    end
  endtask

  initial begin
    test_reset();
    test_fill_wrap();
    test_full_simul();
    test_back_to_back();
    test_simul_empty();
    test_rx_dma();
    test_tx_dma();
    test_clear_priority();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
